// File: rtl/key_regfile_if.sv
// Bus bundle for the key register file: one write port, two registered
// read ports and the scrub control/status lines.
interface key_regfile_if #(
  parameter int B = 8,
  parameter int W = 4
);
  logic         W_E;
  logic [W-1:0] W_A;
  logic [B-1:0] W_D;
  logic         R_E0;
  logic [W-1:0] R_A0;
  logic         R_E1;
  logic [W-1:0] R_A1;
  logic [B-1:0] R_D0;
  logic [B-1:0] R_D1;
  logic         R_V0;
  logic         R_V1;
  logic         zero;
  logic         busy;
  logic         w_drop;

  // Control path side: issues writes, reads and scrub commands.
  modport master (
    output W_E, W_A, W_D, R_E0, R_A0, R_E1, R_A1, zero,
    input  R_D0, R_D1, R_V0, R_V1, busy, w_drop
  );

  // Register file side.
  modport slave (
    input  W_E, W_A, W_D, R_E0, R_A0, R_E1, R_A1, zero,
    output R_D0, R_D1, R_V0, R_V1, busy, w_drop
  );
endinterface

// File: rtl/key_regfile_2r1w.sv
// Key storage register file: 1 write port, 2 registered read ports,
// per-entry valid bits and a scrub sequencer that zeroes every word after
// reset or on a zero command so no key material survives.
module key_regfile_2r1w #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic          clk,
  input  logic          clr,
  key_regfile_if.slave  bus
);

  localparam int DEPTH = 2 ** W;

  typedef enum logic {IDLE, SCRUB} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] ptr, ptr_nxt;
  logic [B-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;

  logic         scrubbing;
  logic         wr_acc;
  logic         wr_ref;
  logic         scrub_start;
  logic [B-1:0] rd0_nxt, rd1_nxt;
  logic         rv0_nxt, rv1_nxt;

  assign scrubbing   = (state == SCRUB);
  assign bus.busy    = clr | scrubbing;
  // A write lands only in IDLE with no zero command and no reset.
  assign wr_acc      = bus.W_E & ~bus.busy & ~bus.zero;
  // Refusals are never flagged during reset.
  assign wr_ref      = bus.W_E & ~clr & (scrubbing | bus.zero);
  assign scrub_start = ~clr & ~scrubbing & bus.zero;

  // Next-state logic of the scrub sequencer.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (bus.zero) begin
          state_nxt = SCRUB;
          ptr_nxt   = '0;
        end
      end
      SCRUB: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == W'(DEPTH - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and scrub pointer registers; reset restarts the sweep from 0.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all sequential state.
    if (clr) begin
      state <= SCRUB;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Storage array: cleared by the scrub sweep, otherwise written by the port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; the scrub sweep clears it, which
    // keeps it mappable to plain RAM/flops without a reset tree.
    if (!clr) begin
      if (scrubbing)   mem[ptr]     <= '0;
      else if (wr_acc) mem[bus.W_A] <= bus.W_D;
    end
  end

  // Valid vector: wiped on reset or scrub start, set by accepted writes.
  always_ff @(posedge clk) begin
    if (clr || scrub_start) valid <= '0;
    else if (wr_acc)        valid[bus.W_A] <= 1'b1;
  end

  // Refused-write pulse, one cycle after the offending W_E.
  always_ff @(posedge clk) begin
    if (clr) bus.w_drop <= 1'b0;
    else     bus.w_drop <= wr_ref;
  end

  // Port 0 lookup: write-first bypass, then blanking of invalid/busy reads.
  always_comb begin
    rd0_nxt = '0;
    rv0_nxt = 1'b0;
    if (wr_acc && (bus.W_A == bus.R_A0)) begin
      rd0_nxt = bus.W_D;
      rv0_nxt = 1'b1;
    end else if (!bus.busy && valid[bus.R_A0]) begin
      rd0_nxt = mem[bus.R_A0];
      rv0_nxt = 1'b1;
    end
  end

  // Port 1 lookup, identical rules to port 0.
  always_comb begin
    rd1_nxt = '0;
    rv1_nxt = 1'b0;
    if (wr_acc && (bus.W_A == bus.R_A1)) begin
      rd1_nxt = bus.W_D;
      rv1_nxt = 1'b1;
    end else if (!bus.busy && valid[bus.R_A1]) begin
      rd1_nxt = mem[bus.R_A1];
      rv1_nxt = 1'b1;
    end
  end

  // Read port 0 output registers; hold when not enabled.
  always_ff @(posedge clk) begin
    if (clr) begin
      bus.R_D0 <= '0;
      bus.R_V0 <= 1'b0;
    end else if (bus.R_E0) begin
      bus.R_D0 <= rd0_nxt;
      bus.R_V0 <= rv0_nxt;
    end
  end

  // Read port 1 output registers; hold when not enabled.
  always_ff @(posedge clk) begin
    if (clr) begin
      bus.R_D1 <= '0;
      bus.R_V1 <= 1'b0;
    end else if (bus.R_E1) begin
      bus.R_D1 <= rd1_nxt;
      bus.R_V1 <= rv1_nxt;
    end
  end

endmodule

// File: tb/tb_key_regfile_2r1w.sv
// Self-checking bench for key_regfile_2r1w: directed steps from the test
// plan followed by a randomized phase, all checked against a behavioural
// model that tracks remaining scrub cycles and a word/valid array.
module tb_key_regfile_2r1w;

  localparam int B = 8;
  localparam int W = 4;
  localparam int DEPTH = 2 ** W;

  logic clk = 1'b0;
  logic clr = 1'b1;

  key_regfile_if #(.B(B), .W(W)) ifc ();

  key_regfile_2r1w #(.B(B), .W(W)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // Stimulus fields applied by step().
  logic         s_clr, s_zero, s_we, s_re0, s_re1;
  logic [W-1:0] s_wa, s_ra0, s_ra1;
  logic [B-1:0] s_wd;
  logic         busy_pre;

  // Reference model.
  logic [B-1:0] m_mem [DEPTH];
  bit           m_val [DEPTH];
  int           scrub_left = 0;
  logic [B-1:0] e_rd0 = '0, e_rd1 = '0;
  logic         e_rv0 = 1'b0, e_rv1 = 1'b0, e_drop = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    s_clr = 1'b0; s_zero = 1'b0; s_we = 1'b0; s_wa = '0; s_wd = '0;
    s_re0 = 1'b0; s_ra0 = '0; s_re1 = 1'b0; s_ra1 = '0;
  endtask

  function automatic void model_read(input logic [W-1:0] a, input bit acc,
                                     input bit busy_now,
                                     output logic [B-1:0] d, output logic v);
    if (acc && s_wa == a) begin
      d = s_wd; v = 1'b1;
    end else if (busy_now || !m_val[a]) begin
      d = '0; v = 1'b0;
    end else begin
      d = m_mem[a]; v = 1'b1;
    end
  endfunction

  // Apply the stimulus fields for one clock, advance the model, check outputs.
  task automatic step();
    bit busy_now, acc;
    @(negedge clk);
    clr = s_clr; ifc.zero = s_zero; ifc.W_E = s_we; ifc.W_A = s_wa; ifc.W_D = s_wd;
    ifc.R_E0 = s_re0; ifc.R_A0 = s_ra0; ifc.R_E1 = s_re1; ifc.R_A1 = s_ra1;
    #1 busy_pre = ifc.busy;
    @(posedge clk);
    busy_now = s_clr || (scrub_left > 0);
    if (s_clr) begin
      scrub_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
      e_rd0 = '0; e_rv0 = 1'b0; e_rd1 = '0; e_rv1 = 1'b0; e_drop = 1'b0;
    end else begin
      acc    = s_we && !busy_now && !s_zero;
      e_drop = s_we && (busy_now || s_zero);
      if (s_re0) model_read(s_ra0, acc, busy_now, e_rd0, e_rv0);
      if (s_re1) model_read(s_ra1, acc, busy_now, e_rd1, e_rv1);
      if (scrub_left > 0) scrub_left--;
      else if (s_zero) begin
        scrub_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
      end
      if (acc) begin
        m_mem[s_wa] = s_wd;
        m_val[s_wa] = 1'b1;
      end
    end
    #1;
    check("R_D0", ifc.R_D0, e_rd0);
    check("R_V0", ifc.R_V0, e_rv0);
    check("R_D1", ifc.R_D1, e_rd1);
    check("R_V1", ifc.R_V1, e_rv1);
    check("w_drop", ifc.w_drop, e_drop);
    check("busy", ifc.busy, s_clr || scrub_left > 0);
  endtask

  // Idle steps reading every address until busy drops; returns busy cycles.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      idle_inputs();
      s_re0 = 1'b1; s_ra0 = W'(i); s_re1 = 1'b1; s_ra1 = W'(DEPTH - 1 - i);
      step();
      if (!busy_pre) break;
      n++;
    end
  endtask

  task automatic do_write(input logic [W-1:0] a, input logic [B-1:0] d);
    idle_inputs(); s_we = 1'b1; s_wa = a; s_wd = d; step();
  endtask

  task automatic do_read0(input logic [W-1:0] a);
    idle_inputs(); s_re0 = 1'b1; s_ra0 = a; step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    ifc.W_E = 1'b0; ifc.W_A = '0; ifc.W_D = '0; ifc.zero = 1'b0;
    ifc.R_E0 = 1'b0; ifc.R_A0 = '0; ifc.R_E1 = 1'b0; ifc.R_A1 = '0;

    // Reset: two clr cycles, release, 16 busy cycles, every read blank.
    idle_inputs(); s_clr = 1'b1; step(); step();
    check("reset_busy_during_clr", busy_pre, 1'b1);
    count_busy(n);
    check("reset_busy_cycles", n, DEPTH);
    check("reset_word15", u_dut.mem[DEPTH-1], '0);
    for (int a = 0; a < DEPTH; a++) begin
      do_read0(W'(a));
      check("reset_read_d", ifc.R_D0, 8'h00);
      check("reset_read_v", ifc.R_V0, 1'b0);
    end

    // Write / read.
    do_write(4'd3, 8'hA5);
    do_read0(4'd3);
    check("wr_rd_d", ifc.R_D0, 8'hA5);
    check("wr_rd_v", ifc.R_V0, 1'b1);
    do_read0(4'd4);
    check("unwritten_d", ifc.R_D0, 8'h00);
    check("unwritten_v", ifc.R_V0, 1'b0);

    // Bypass on both ports.
    idle_inputs(); s_we = 1'b1; s_wa = 4'd7; s_wd = 8'h3C;
    s_re0 = 1'b1; s_ra0 = 4'd7; s_re1 = 1'b1; s_ra1 = 4'd7; step();
    check("bypass_d0", ifc.R_D0, 8'h3C);
    check("bypass_d1", ifc.R_D1, 8'h3C);
    check("bypass_v0", ifc.R_V0, 1'b1);
    check("bypass_v1", ifc.R_V1, 1'b1);

    // Hold: R_E0 low keeps the previous result.
    do_write(4'd2, 8'h5A);
    do_read0(4'd2);
    idle_inputs(); s_ra0 = 4'd5; step();
    check("hold_d", ifc.R_D0, 8'h5A);
    check("hold_v", ifc.R_V0, 1'b1);

    // Refused write in the third scrub cycle.
    idle_inputs(); s_zero = 1'b1; step();
    idle_inputs(); step(); step();
    idle_inputs(); s_we = 1'b1; s_wa = 4'd9; s_wd = 8'h11; step();
    check("refused_drop", ifc.w_drop, 1'b1);
    idle_inputs(); step();
    check("refused_drop_single", ifc.w_drop, 1'b0);
    count_busy(n);
    check("refused_rest_busy", n, DEPTH - 4);
    do_read0(4'd9);
    check("refused_d", ifc.R_D0, 8'h00);
    check("refused_v", ifc.R_V0, 1'b0);

    // zero command with a simultaneous write after filling with 0xFF.
    for (int a = 0; a < DEPTH; a++) do_write(W'(a), 8'hFF);
    idle_inputs(); s_zero = 1'b1; s_we = 1'b1; s_wa = 4'd1; s_wd = 8'h22; step();
    check("zero_drop", ifc.w_drop, 1'b1);
    count_busy(n);
    check("zero_busy_cycles", n, DEPTH);
    check("zero_word15", u_dut.mem[DEPTH-1], '0);
    for (int a = 0; a < DEPTH; a++) begin
      idle_inputs(); s_re0 = 1'b1; s_ra0 = W'(a); s_re1 = 1'b1; s_ra1 = W'(a); step();
      check("zero_read_d", ifc.R_D1, 8'h00);
      check("zero_read_v", ifc.R_V1, 1'b0);
    end

    // Mid-scrub reset at scrub cycle 8 restarts the sweep.
    idle_inputs(); s_zero = 1'b1; step();
    idle_inputs(); repeat (7) step();
    idle_inputs(); s_clr = 1'b1; step();
    count_busy(n);
    check("midreset_busy_cycles", n, DEPTH);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      idle_inputs();
      s_clr  = ($urandom_range(0, 99) == 0);
      s_zero = ($urandom_range(0, 39) == 0);
      s_we   = $urandom_range(0, 1);
      s_wa   = W'($urandom);
      s_wd   = B'($urandom);
      s_re0  = ($urandom_range(0, 3) != 0);
      s_re1  = ($urandom_range(0, 3) != 0);
      s_ra0  = ($urandom_range(0, 3) == 0) ? s_wa : W'($urandom);
      s_ra1  = ($urandom_range(0, 3) == 0) ? s_ra0 : W'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
